// File: rtl/divider_share_pkg.sv
// divider_share_pkg: FSM state encodings shared by the divider-sharing controller.
package divider_share_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
endpackage

// File: rtl/divider_rr_arbiter.sv
// divider_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module divider_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int IDSIZE = 2
) (
  input  logic [N_REQ-1:0]  req_i,
  input  logic [IDSIZE-1:0] ptr_i,
  output logic [N_REQ-1:0]  gnt_oh_o,
  output logic [IDSIZE-1:0] gnt_idx_o,
  output logic              vld_o
);
  int j;
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    vld_o     = 1'b0;
    j         = 0;
    // Scan farthest offset first so the closest requester to ptr overwrites the rest.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (req_i[j]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[j] = 1'b1;
        gnt_idx_o   = IDSIZE'(j);
        vld_o       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/divider_share_ctrl.sv
// divider_share_ctrl: round-robin sharing of one divider with local div-by-zero and watchdog abort.
module divider_share_ctrl
  import divider_share_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BITSIZE   = 16,
  parameter int IDSIZE    = 2,
  parameter int TIMEOUT   = 64,
  parameter int TOCNTSIZE = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BITSIZE-1:0]   dividend_in,
  input  logic [N_REQ*BITSIZE-1:0]   divisor_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rsp_valid,
  output logic [IDSIZE-1:0]          rsp_id,
  output logic [BITSIZE-1:0]         rsp_quotient,
  output logic [BITSIZE-1:0]         rsp_remainder,
  output logic                       rsp_div0,
  output logic                       rsp_timeout,
  output logic                       busy,
  output logic                       div_strt,
  output logic [BITSIZE-1:0]         div_dividend,
  output logic [BITSIZE-1:0]         div_divisor,
  output logic                       div_rst,
  input  logic                       div_idle,
  input  logic [BITSIZE-1:0]         div_quotient,
  input  logic [BITSIZE-1:0]         div_remainder
);
  logic [1:0]           state_q, state_d;
  logic [IDSIZE-1:0]    ptr_q, id_q, win_idx, rsp_id_q;
  logic [N_REQ-1:0]     win_oh, gnt_q;
  logic                 win_vld, win_div0, div_done, abort, abort_q;
  logic [TOCNTSIZE-1:0] wd_q;
  logic [BITSIZE-1:0]   dvd_q, dvs_q, q_q, r_q, win_dvd, win_dvs;
  logic                 div0_q, to_q;
  logic [BITSIZE-1:0]   dvd_a [N_REQ];
  logic [BITSIZE-1:0]   dvs_a [N_REQ];
  divider_rr_arbiter #(.N_REQ(N_REQ), .IDSIZE(IDSIZE)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx),
    .vld_o     (win_vld)
  );
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      dvd_a[i] = dividend_in[i*BITSIZE +: BITSIZE];
      dvs_a[i] = divisor_in[i*BITSIZE +: BITSIZE];
    end
  end
  assign win_dvd  = dvd_a[win_idx];
  assign win_dvs  = dvs_a[win_idx];
  assign win_div0 = win_dvs == '0;
  // The first WAIT cycle (wd_q==0) may still see the divider's pre-launch idle.
  assign div_done = state_q == S_WAIT && wd_q != '0 && div_idle;
  assign abort    = state_q == S_WAIT && wd_q == TOCNTSIZE'(TIMEOUT) && !div_done;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = win_vld ? (win_div0 ? S_RESP : S_LAUNCH) : S_IDLE;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   state_d = (div_done || abort) ? S_RESP : S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      abort_q  <= 1'b0;
      wd_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      div0_q   <= 1'b0;
      to_q     <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= state_q == S_IDLE ? win_oh : '0;
      abort_q <= abort;
      wd_q    <= state_q == S_WAIT ? wd_q + 1'b1 : '0;
      if (state_q == S_IDLE && win_vld) begin
        ptr_q <= win_idx == IDSIZE'(N_REQ - 1) ? '0 : win_idx + 1'b1;
        id_q  <= win_idx;
        dvd_q <= win_dvd;
        dvs_q <= win_dvs;
        if (win_div0) begin
          q_q      <= '1;
          r_q      <= win_dvd;
          div0_q   <= 1'b1;
          to_q     <= 1'b0;
          rsp_id_q <= win_idx;
        end
      end
      if (div_done || abort) begin
        q_q      <= div_done ? div_quotient : '0;
        r_q      <= div_done ? div_remainder : '0;
        div0_q   <= 1'b0;
        to_q     <= abort;
        rsp_id_q <= id_q;
      end
    end
  end
  assign gnt           = gnt_q;
  assign rsp_valid     = state_q == S_RESP;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = q_q;
  assign rsp_remainder = r_q;
  assign rsp_div0      = div0_q;
  assign rsp_timeout   = to_q;
  assign busy          = state_q != S_IDLE;
  assign div_strt      = state_q == S_LAUNCH;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign div_rst       = ~rst_n | abort_q;
endmodule
